// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, coordinate type and counter-width helper.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_timing_pkg;

   localparam int CLK_DIV     = 2;
   localparam int H_ACTIVE    = 640;
   localparam int H_FP        = 16;
   localparam int H_SYNC      = 96;
   localparam int H_BP        = 48;
   localparam int V_ACTIVE    = 480;
   localparam int V_FP        = 10;
   localparam int V_SYNC      = 2;
   localparam int V_BP        = 33;
   localparam int STEP_FRAMES = 30;

   // Derived raster geometry; the *_END values are exclusive bounds.
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   typedef logic [9:0] coord_t;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: modulo-(MAX+1) counter advancing on enable, with a wrap strobe.
// Latency: count updates on the clock after enable; wrap is combinational (enable && count==MAX).
// Backpressure: none; enable is the only flow control.
module wrap_counter
   import vga_timing_pkg::*;
#(
   parameter int MAX   = 1,
   parameter int WIDTH = cnt_width(MAX)
) (
   input  logic             clock_50,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic at_max;

   assign at_max = (count == MAX_V);
   assign wrap   = enable && at_max;

   // Advance on enable, returning to zero after MAX.
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         count <= at_max ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster scan generator (syncs, video_on, clamped x/y, pixel/frame/step strobes).
// Latency: every output is a registered decode, one clock_50 behind the counters, all aligned.
// Backpressure: none; free-running raster. Define VGA_FRAME_PACER_EN for one step_tick per STEP_FRAMES frames.
module vga_timing_gen #(
   parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
   parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP        = vga_timing_pkg::H_FP,
   parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int H_BP        = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP        = vga_timing_pkg::V_FP,
   parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int V_BP        = vga_timing_pkg::V_BP,
   parameter int STEP_FRAMES = vga_timing_pkg::STEP_FRAMES
) (
   input  logic                    clock_50,
   input  logic                    reset,
   output vga_timing_pkg::coord_t  x,
   output vga_timing_pkg::coord_t  y,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    video_on,
   output logic                    pix_tick,
   output logic                    frame_start,
   output logic                    step_tick
);

   import vga_timing_pkg::*;

   // Geometry for this instance (parameters may override the package defaults).
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_LO = H_ACTIVE + H_FP;
   localparam int HS_HI = HS_LO + H_SYNC;
   localparam int VS_LO = V_ACTIVE + V_FP;
   localparam int VS_HI = VS_LO + V_SYNC;

   localparam int DW = cnt_width(CLK_DIV - 1);
   localparam int HW = cnt_width(H_TOT - 1);
   localparam int VW = cnt_width(V_TOT - 1);

   logic [DW-1:0] div_cnt;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          pix_en;
   logic          h_wrap;
   logic          v_wrap_unused;

   logic active;
   logic hs_zone;
   logic vs_zone;
   logic at_origin;
   logic vblank_start;
   logic step_ev;

   // Pixel enable: last clock of each CLK_DIV-long pixel period.
   wrap_counter #(.MAX(CLK_DIV - 1), .WIDTH(DW)) u_div_cnt (
      .clock_50 (clock_50),
      .reset    (reset),
      .enable   (1'b1),
      .count    (div_cnt),
      .wrap     (pix_en)
   );

   wrap_counter #(.MAX(H_TOT - 1), .WIDTH(HW)) u_h_cnt (
      .clock_50 (clock_50),
      .reset    (reset),
      .enable   (pix_en),
      .count    (h_cnt),
      .wrap     (h_wrap)
   );

   // Lines advance on the pixel enable that wraps the line.
   wrap_counter #(.MAX(V_TOT - 1), .WIDTH(VW)) u_v_cnt (
      .clock_50 (clock_50),
      .reset    (reset),
      .enable   (h_wrap),
      .count    (v_cnt),
      .wrap     (v_wrap_unused)
   );

   assign active       = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
   assign hs_zone      = (int'(h_cnt) >= HS_LO) && (int'(h_cnt) < HS_HI);
   assign vs_zone      = (int'(v_cnt) >= VS_LO) && (int'(v_cnt) < VS_HI);
   assign at_origin    = pix_en && (h_cnt == '0) && (v_cnt == '0);
   assign vblank_start = pix_en && (h_cnt == '0) && (int'(v_cnt) == V_ACTIVE);

`ifdef VGA_FRAME_PACER_EN
   logic [7:0] frame_cnt;
   logic       frame_wrap_unused;

   // Frame pacer: counts vblank starts, fires on the last of every STEP_FRAMES.
   wrap_counter #(.MAX(STEP_FRAMES - 1), .WIDTH(8)) u_frame_cnt (
      .clock_50 (clock_50),
      .reset    (reset),
      .enable   (vblank_start),
      .count    (frame_cnt),
      .wrap     (frame_wrap_unused)
   );

   assign step_ev = vblank_start && (int'(frame_cnt) == STEP_FRAMES - 1);
`else
   localparam int STEP_FRAMES_UNUSED = STEP_FRAMES;

   assign step_ev = vblank_start;
`endif

   // Registered decode of the counters; x/y are forced to 0 outside the visible area
   // so the downstream cell index never leaves the grid.
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         x           <= '0;
         y           <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
         step_tick   <= 1'b0;
      end else begin
         x           <= active ? coord_t'(h_cnt) : '0;
         y           <= active ? coord_t'(v_cnt) : '0;
         hsync       <= !hs_zone;
         vsync       <= !vs_zone;
         video_on    <= active;
         pix_tick    <= pix_en;
         frame_start <= at_origin;
         step_tick   <= step_ev;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen with a shortened vertical raster.
// Latency: expected event cycles are queued by the stimulus and popped by a negedge monitor.
// Backpressure: n/a.
module tb_vga_timing_gen;

   // Full horizontal timing, 8-line frame so several frames fit in a short run.
   localparam int V_ACTIVE_TB = 4;
   localparam int H_TOT_TB    = 800;            // 640+16+96+48
   localparam int V_TOT_TB    = 8;              // 4+1+2+1
   localparam int FRAME_CLKS  = 12800;          // 800*8*2
   localparam int HS_LEN      = 192;            // 96 pixels * 2 clocks
   localparam int VS_LEN      = 3200;           // 2 lines * 1600 clocks
   localparam int LINE_PIX    = H_TOT_TB * V_TOT_TB;

   typedef struct {
      int t;
      int aux;
   } ev_t;

   logic       clock_50 = 1'b0;
   logic       reset    = 1'b1;
   logic [9:0] x;
   logic [9:0] y;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       pix_tick;
   logic       frame_start;
   logic       step_tick;

   vga_timing_gen #(
      .CLK_DIV     (2),
      .H_ACTIVE    (640),
      .H_FP        (16),
      .H_SYNC      (96),
      .H_BP        (48),
      .V_ACTIVE    (V_ACTIVE_TB),
      .V_FP        (1),
      .V_SYNC      (2),
      .V_BP        (1),
      .STEP_FRAMES (3)
   ) dut (
      .clock_50    (clock_50),
      .reset       (reset),
      .x           (x),
      .y           (y),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .pix_tick    (pix_tick),
      .frame_start (frame_start),
      .step_tick   (step_tick)
   );

   always #10 clock_50 = ~clock_50;

   int cyc = 0;
   always @(posedge clock_50) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   int  q_fs[$];
   int  q_hs[$];
   int  q_vs[$];
   int  q_st[$];
   ev_t q_vo[$];

   int t0    = 0;
   bit t0_ok = 1'b0;

   int clamp_bad = 0;
   int tick_bad  = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit pace(input int f);
`ifdef VGA_FRAME_PACER_EN
      return (f % 3) == 2;
`else
      return f >= 0;
`endif
   endfunction

   // Cycle (as sampled on negedge) of pixel (l,h) of frame f: the pix_tick cycle,
   // or one clock earlier for the first cycle the decoded outputs show that pixel.
   function automatic int at(input int base, input int f, input int l, input int h, input bit tick);
      return base + f * FRAME_CLKS + 2 * (l * H_TOT_TB + h) - (tick ? 0 : 1);
   endfunction

   // Queue every event of frame f whose pixel index lies below cutoff.
   task automatic push_frame(input int base, input int f, input int cutoff);
      ev_t e;
      if (cutoff > 0) q_fs.push_back(at(base, f, 0, 0, 1'b1));
      for (int l = 0; l < V_TOT_TB; l++)
         if (l * H_TOT_TB + 656 < cutoff) q_hs.push_back(at(base, f, l, 656, 1'b0));
      for (int l = 0; l < V_ACTIVE_TB; l++)
         if (l * H_TOT_TB + 640 < cutoff) begin
            e.t   = at(base, f, l, 640, 1'b0);
            e.aux = l;
            q_vo.push_back(e);
         end
      if (5 * H_TOT_TB < cutoff) q_vs.push_back(at(base, f, 5, 0, 1'b0));
      if (pace(f) && (4 * H_TOT_TB < cutoff)) q_st.push_back(at(base, f, 4, 0, 1'b1));
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_x"},           int'(x),     0);
      check({pfx, "_y"},           int'(y),     0);
      check({pfx, "_hsync"},       int'(hsync), 1);
      check({pfx, "_vsync"},       int'(vsync), 1);
      check({pfx, "_video_on"},    int'(video_on), 0);
      check({pfx, "_pix_tick"},    int'(pix_tick), 0);
      check({pfx, "_frame_start"}, int'(frame_start), 0);
      check({pfx, "_step_tick"},   int'(step_tick), 0);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clock_50);
   endtask

   // Monitor: pops expected events as the DUT presents them, tracks pulse widths.
   initial begin
      logic       p_vo;
      logic       p_hs;
      logic       p_vs;
      logic [9:0] p_x;
      logic [9:0] p_y;
      int         hs_run;
      int         vs_run;
      bit         exp_tick;
      ev_t        e;
      p_vo = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_x = '0; p_y = '0;
      hs_run = 0; vs_run = 0;
      forever begin
         @(negedge clock_50);
         if (reset) begin
            p_vo = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_x = '0; p_y = '0;
            hs_run = 0; vs_run = 0;
         end else begin
            if (frame_start) begin
               if (q_fs.size() == 0) check("frame_start_extra", cyc, -1);
               else check("frame_start_cyc", cyc, q_fs.pop_front());
            end
            if (step_tick) begin
               if (q_st.size() == 0) check("step_tick_extra", cyc, -1);
               else check("step_tick_cyc", cyc, q_st.pop_front());
            end
            if (!hsync && p_hs) begin
               if (q_hs.size() == 0) check("hsync_fall_extra", cyc, -1);
               else check("hsync_fall_cyc", cyc, q_hs.pop_front());
            end
            if (!hsync) hs_run++;
            else if (!p_hs) begin
               check("hsync_width", hs_run, HS_LEN);
               hs_run = 0;
            end
            if (!vsync && p_vs) begin
               if (q_vs.size() == 0) check("vsync_fall_extra", cyc, -1);
               else check("vsync_fall_cyc", cyc, q_vs.pop_front());
            end
            if (!vsync) vs_run++;
            else if (!p_vs) begin
               check("vsync_width", vs_run, VS_LEN);
               vs_run = 0;
            end
            if (!video_on && p_vo) begin
               if (q_vo.size() == 0) check("video_fall_extra", cyc, -1);
               else begin
                  e = q_vo.pop_front();
                  check("video_fall_cyc", cyc, e.t);
                  check("last_x", int'(p_x), 639);
                  check("last_y", int'(p_y), e.aux);
               end
            end
            if ((int'(x) > 639) || (int'(y) > V_ACTIVE_TB - 1) ||
                (!video_on && ((x != '0) || (y != '0))))
               clamp_bad++;
            exp_tick = t0_ok && (cyc >= t0) && (((cyc - t0) % 2) == 0);
            if (pix_tick != exp_tick) tick_bad++;
            p_vo = video_on; p_hs = hsync; p_vs = vsync; p_x = x; p_y = y;
         end
      end
   end

   // Stimulus: reset, four full frames, reset at line 2 pixel 700, one more frame.
   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clock_50);
      #1;
      check_reset("init");
      @(negedge clock_50);
      t0    = cyc + 2;
      t0_ok = 1'b1;
      for (int f = 0; f < 4; f++) push_frame(t0, f, LINE_PIX);
      push_frame(t0, 4, 2 * H_TOT_TB + 700);
      reset = 1'b0;

      wait_until(t0 + 4 * FRAME_CLKS + 2 * (2 * H_TOT_TB + 700));
      check("pre_reset_hsync_low", int'(hsync), 0);
      reset = 1'b1;
      #1;
      check_reset("midframe");
      repeat (3) @(negedge clock_50);
      t0 = cyc + 2;
      push_frame(t0, 0, LINE_PIX);
      push_frame(t0, 1, 1);
      reset = 1'b0;

      wait_until(t0 + FRAME_CLKS + 4);
      check("left_frame_start", q_fs.size(), 0);
      check("left_hsync",       q_hs.size(), 0);
      check("left_vsync",       q_vs.size(), 0);
      check("left_video_fall",  q_vo.size(), 0);
      check("left_step_tick",   q_st.size(), 0);
      check("clamp_violations", clamp_bad, 0);
      check("pix_tick_violations", tick_bad, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog in case the stimulus never reaches its end.
   initial begin
      #(90000 * 20);
      $display("FAIL watchdog: simulation reached cycle %0d, required finish before 90000", cyc);
      $fatal(1, "watchdog");
   end

endmodule
